// File: rtl/sub_share_pkg.sv
// Shared types and helpers for the shared-subtractor arbiter.
// Holds the FSM state encoding, datapath width and the condition-flag bundle.
package sub_share_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic borrow;
    logic ovf;
  } flags_t;

  // Borrow comes from an unsigned compare of the operands, not from the difference.
  function automatic flags_t calc_flags(input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b,
                                        input logic [DATA_W-1:0] diff);
    flags_t f;
    f.zero   = (diff == '0);
    f.neg    = diff[DATA_W-1];
    f.borrow = (a < b);
    f.ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
    return f;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of valid searching upward from ptr with wrap.
module rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = (32'(ptr) + i) % N_REQ;
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/sub32.sv
// Combinational 32-bit subtractor: out = a - b, modulo 2^32.
module sub32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);

  assign out = a - b;

endmodule

// File: rtl/sub_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit subtractor among N_REQ requesters.
// One operation in flight: IDLE accepts, EXEC computes, RESP holds the tagged result.
module sub_share_arbiter
  import sub_share_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_diff,
  output logic                    rsp_zero,
  output logic                    rsp_neg,
  output logic                    rsp_borrow,
  output logic                    rsp_ovf,
  output logic                    busy
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] diff_q, diff_d;
  flags_t            flags_q, flags_d;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic [DATA_W-1:0] sub_out;
  int unsigned       sel_lsb;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  sub32 u_sub32 (
    .a   (a_q),
    .b   (b_q),
    .out (sub_out)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    rsp_id_d  = rsp_id_q;
    a_d       = a_q;
    b_d       = b_q;
    diff_d    = diff_q;
    flags_d   = flags_q;
    req_ready = '0;
    sel_lsb   = 32'(grant_idx) * DATA_W;

    unique case (state_q)
      IDLE: begin
        // Grant depends only on req_valid and rr_ptr, never on rsp_ready.
        req_ready = grant;
        if (grant_any) begin
          a_d      = req_a[sel_lsb +: DATA_W];
          b_d      = req_b[sel_lsb +: DATA_W];
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        diff_d   = sub_out;
        flags_d  = calc_flags(a_q, b_q, sub_out);
        rsp_id_d = id_q;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      rsp_id_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      rsp_id_q <= rsp_id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      flags_q  <= flags_d;
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_id     = rsp_id_q;
  assign rsp_diff   = diff_q;
  assign rsp_zero   = flags_q.zero;
  assign rsp_neg    = flags_q.neg;
  assign rsp_borrow = flags_q.borrow;
  assign rsp_ovf    = flags_q.ovf;

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Directed bench for sub_share_arbiter: flag vector table plus round-robin,
// backpressure and mid-operation reset sequences.
module tb_sub_share_arbiter;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [0:0]    rsp_id;
  logic [31:0]   rsp_diff;
  logic          rsp_zero, rsp_neg, rsp_borrow, rsp_ovf;
  logic          busy;

  int n_chk = 0;
  int n_fail = 0;

  sub_share_arbiter #(.N_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_diff   (rsp_diff),
    .rsp_zero   (rsp_zero),
    .rsp_neg    (rsp_neg),
    .rsp_borrow (rsp_borrow),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // flags packed as {zero, neg, borrow, ovf}
  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] diff;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b);
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
  endtask

  function automatic logic [3:0] flags_now();
    return {rsp_zero, rsp_neg, rsp_borrow, rsp_ovf};
  endfunction

  int acc_who[$];
  int acc_cyc[$];
  int rsp_ids[$];
  logic [31:0] rsp_diffs[$];
  logic [3:0] held_fl;

  initial begin
    vecs[0] = '{0, 32'h0000000A, 32'h00000003, 32'h00000007, 4'b0000};
    vecs[1] = '{1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1000};
    vecs[2] = '{0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0110};
    vecs[3] = '{1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001};
    vecs[4] = '{0, 32'h00000001, 32'h80000000, 32'h80000001, 4'b0111};
    vecs[5] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000};
    vecs[6] = '{0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 4'b0111};

    // Reset and idle
    #1;
    chk("in_reset_outputs", {rsp_valid, rsp_id, rsp_diff, flags_now(), busy, req_ready}, '0);
    reset_dut();
    for (int c = 0; c < 10; c++) begin
      chk("idle_outputs", {rsp_valid, rsp_id, rsp_diff, flags_now(), busy, req_ready}, '0);
      tick();
    end

    // Single operations from the vector table
    foreach (vecs[k]) begin
      set_op(vecs[k].r, vecs[k].a, vecs[k].b);
      req_valid = '0;
      req_valid[vecs[k].r] = 1'b1;
      #1;
      chk("vec_ready", req_ready, 64'(req_valid));
      tick();
      req_valid = '0;
      #1;
      chk("vec_exec", {busy, rsp_valid, req_ready}, {1'b1, 1'b0, 2'b00});
      tick();
      chk("vec_rsp_valid", rsp_valid, 1'b1);
      chk("vec_rsp_id", rsp_id, 64'(vecs[k].r));
      chk("vec_diff", rsp_diff, vecs[k].diff);
      chk("vec_flags", flags_now(), vecs[k].fl);
      tick();
      chk("vec_done", {rsp_valid, busy}, 2'b00);
    end

    // Round-robin with both requesters held valid
    reset_dut();
    set_op(0, 32'd100, 32'd1);
    set_op(1, 32'd200, 32'd2);
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 14; c++) begin
      if (req_ready == 2'b01) begin acc_who.push_back(0); acc_cyc.push_back(c); end
      if (req_ready == 2'b10) begin acc_who.push_back(1); acc_cyc.push_back(c); end
      if (rsp_valid) begin rsp_ids.push_back(int'(rsp_id)); rsp_diffs.push_back(rsp_diff); end
      tick();
    end
    req_valid = '0;
    chk("rr_accept_count", 64'(acc_who.size() >= 4), 1);
    chk("rr_rsp_count", 64'(rsp_ids.size() >= 4), 1);
    if (acc_who.size() >= 4 && rsp_ids.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr_accept_who", acc_who[i], i % 2);
        chk("rr_accept_cycle", acc_cyc[i], 3 * i);
        chk("rr_rsp_id", rsp_ids[i], i % 2);
        chk("rr_rsp_diff", rsp_diffs[i], (i % 2 == 0) ? 32'd99 : 32'd198);
      end
    end
    repeat (3) tick();

    // Backpressure in RESP
    reset_dut();
    rsp_ready = 1'b0;
    set_op(1, 32'h12345678, 32'h00000678);
    req_valid = 2'b10;
    #1;
    chk("bp_ready_1", req_ready, 2'b10);
    tick();
    set_op(0, 32'd50, 32'd8);
    req_valid = 2'b11;
    #1;
    chk("bp_exec", {busy, rsp_valid, req_ready}, {1'b1, 1'b0, 2'b00});
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid_id", {rsp_valid, rsp_id}, 2'b11);
      chk("bp_hold_diff", rsp_diff, 32'h12345000);
      chk("bp_hold_flags", flags_now(), 4'b0000);
      chk("bp_hold_ready", req_ready, 2'b00);
      tick();
    end
    chk("bp_still_resp", {rsp_valid, rsp_diff}, {1'b1, 32'h12345000});
    rsp_ready = 1'b1;
    tick();
    chk("bp_after_hs", {rsp_valid, busy, req_ready}, {1'b0, 1'b0, 2'b01});
    tick();
    req_valid = '0;
    #1;
    chk("bp_new_accept", {busy, req_ready}, {1'b1, 2'b00});
    tick();
    chk("bp_rsp2", {rsp_valid, rsp_id, rsp_diff}, {1'b1, 1'b0, 32'd42});
    tick();
    chk("bp_done", rsp_valid, 1'b0);

    // Reset during EXEC discards the op and returns rr_ptr to 0
    reset_dut();
    set_op(0, 32'd9, 32'd4);
    set_op(1, 32'd20, 32'd7);
    req_valid = 2'b01;
    #1;
    chk("mr_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    #1;
    chk("mr_exec", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_in_reset", {busy, rsp_valid, rsp_diff}, '0);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("mr_no_rsp", {rsp_valid, busy}, 2'b00);
    end
    req_valid = 2'b11;
    #1;
    chk("mr_grant0", req_ready, 2'b01);
    tick();
    req_valid = '0;
    tick();
    chk("mr_rsp", {rsp_valid, rsp_id, rsp_diff}, {1'b1, 1'b0, 32'd5});
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
